writeback_sequencer: RTL and testbench
======================================

// Module: writeback_sequencer
// PURPOSE
//   Sole writer of the RV32E register file. Arbitrates ALU results against in-order load
//   returns and issues at most one registered write per clock on the register-file write port.
//   Tracks outstanding load destinations in a tag queue and exports a busy mask, so decode can
//   stall on RAW/WAW hazards. Sits between execute/LSU and the register file.
// PARAMETERS
//   DATA_W    32  width of the write value
//   NREG      16  number of architectural registers (RV32E); index width is 4
//   LD_DEPTH  2   maximum outstanding loads (tag queue entries)
// PORTS
//   clk         in   1       single clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   alu_valid   in   1       ALU result offered
//   alu_rd      in   4       ALU destination register
//   alu_data    in   DATA_W  ALU result
//   alu_ready   out  1       ALU result accepted this cycle (alu_valid && alu_ready)
//   ld_issue    in   1       load issued; pushes ld_rd into the tag queue
//   ld_rd       in   4       destination register of the issued load
//   issue_ok    out  1       tag queue not full; ld_issue is legal only when issue_ok=1
//   ld_valid    in   1       load data returned (in issue order)
//   ld_data     in   DATA_W  returned load data
//   ld_ready    out  1       load data accepted this cycle (ld_valid && ld_ready)
//   wb_reg      out  4       register-file write index
//   wb_value    out  DATA_W  register-file write data
//   wb_en       out  1       register-file write strobe, one-cycle pulse
//   busy_mask   out  NREG    bit i=1: register i has a pending load in the queue
// BEHAVIOUR
//   Reset (async, rst=1): wb_en=0, wb_reg=0, wb_value=0, tag queue emptied, busy_mask=0.
//     Outstanding loads are discarded. A ld_valid arriving after reset with an empty queue
//     is not accepted (ld_ready=0).
//   Tag queue: FIFO of LD_DEPTH 4-bit rd entries. Push on ld_issue && issue_ok; pop on load
//     accept. Push and pop in the same cycle are both performed; count is unchanged.
//     ld_issue while full is dropped; no state changes.
//   issue_ok  = (count < LD_DEPTH), combinational.
//   ld_ready  = (count != 0), combinational. Load data pairs with the queue head rd.
//   busy_mask = OR over valid entries of onehot(rd); entries with rd=0 never set a bit.
//     A bit clears only when no remaining valid entry names that rd. Purely combinational
//     from queue state, so it updates the cycle after a push or pop.
//   Arbitration: a load return has priority. When ld_valid && ld_ready, alu_ready=0.
//     alu_ready=0 also when busy_mask[alu_rd]=1 (WAW: an ALU write must not be overwritten by
//     an older load). Otherwise alu_ready=1. Both ready terms are combinational.
//   Write issue (registered, latency 1): accept at edge N -> during cycle N+1 wb_en=1,
//     wb_reg=rd, wb_value=data. With no accept at edge N, wb_en=0 in N+1, and wb_reg and
//     wb_value hold their last values.
//   x0: an accepted transfer with rd=0 completes its handshake, pops the queue if it is a
//     load, and leaves wb_en=0.
//   Throughput: one writeback per clock, sustained. Back-to-back accepts produce consecutive
//     wb_en pulses.
//   Ordering: loads retire strictly in issue order. ALU results may retire between loads.
// TESTING
//   1 Reset: assert rst mid-cycle with 2 loads pending -> wb_en=0, busy_mask=0, issue_ok=1,
//     ld_ready=0 immediately.
//   2 ALU only: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle wb_en=1,
//     wb_reg=5, wb_value=0xDEADBEEF; following cycle wb_en=0.
//   3 Load queue: issue rd=3, then rd=7 -> busy_mask=0x0088, issue_ok=0; third issue
//     (rd=9) is dropped. Return 0x11 then 0x22 -> writes x3=0x11, then x7=0x22; mask=0.
//   4 Conflict: ld_valid (head rd=2, 0xAA) with alu_valid rd=4 in the same cycle -> load
//     writes first; ALU is held (alu_ready=0) and writes x4 the next cycle.
//   5 WAW stall: load pending to rd=6, alu_valid rd=6 -> alu_ready=0 until the load retires;
//     then the ALU write lands after it.
//   6 x0 and same-rd: issue two loads to rd=0 -> busy_mask=0. Returns are accepted with
//     wb_en=0. Two loads to rd=8 -> bit 8 stays set until the second one retires.

Source files
------------

// File: rtl/writeback_sequencer_if.sv
// rtl/writeback_sequencer_if.sv - writeback sequencer handshake bundle
// Carries the ALU result port, load issue/return ports, register-file write port and busy mask.
interface writeback_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
);
  logic              alu_valid;
  logic [3:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_issue;
  logic [3:0]        ld_rd;
  logic              issue_ok;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [3:0]        wb_reg;
  logic [DATA_W-1:0] wb_value;
  logic              wb_en;
  logic [NREG-1:0]   busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_valid, ld_data,
    input  alu_ready, issue_ok, ld_ready, wb_reg, wb_value, wb_en, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_rd, ld_valid, ld_data,
    output alu_ready, issue_ok, ld_ready, wb_reg, wb_value, wb_en, busy_mask
  );
endinterface

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - register-file writeback arbiter with in-order load tag queue
// Load returns beat ALU results; ALU writes to a register with a pending load are held (WAW).
module writeback_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int LD_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  writeback_sequencer_if.slave          seq_io
);
  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);

  logic [3:0]        tag_q [LD_DEPTH];
  logic [LD_DEPTH-1:0] vld_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;

  logic              wb_en_q, wb_en_d;
  logic [3:0]        wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;

  logic              push, pop, alu_acc, alu_ready;
  logic [3:0]        head_rd;
  logic [NREG-1:0]   busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_rd   = tag_q[rd_ptr_q];
  assign push      = seq_io.ld_issue && (count_q < CW'(LD_DEPTH));
  assign pop       = seq_io.ld_valid && (count_q != '0);
  assign alu_ready = !pop && !busy[seq_io.alu_rd];
  assign alu_acc   = seq_io.alu_valid && alu_ready;

  // x0 never marks a register busy, so ALU writes to x0 are never stalled.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (vld_q[i] && (tag_q[i] != 4'd0)) begin
        busy[tag_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        tag_q[i] <= 4'd0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= ptr_inc(rd_ptr_q);
      end
      if (push) begin
        tag_q[wr_ptr_q] <= seq_io.ld_rd;
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Index and data only move on a real write; an x0 accept leaves them holding.
  always_comb begin
    wb_en_d    = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_value_d = wb_value_q;
    if (pop) begin
      if (head_rd != 4'd0) begin
        wb_en_d    = 1'b1;
        wb_reg_d   = head_rd;
        wb_value_d = seq_io.ld_data;
      end
    end else if (alu_acc && (seq_io.alu_rd != 4'd0)) begin
      wb_en_d    = 1'b1;
      wb_reg_d   = seq_io.alu_rd;
      wb_value_d = seq_io.alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      wb_reg_q   <= 4'd0;
      wb_value_q <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      wb_value_q <= wb_value_d;
    end
  end

  assign seq_io.alu_ready = alu_ready;
  assign seq_io.issue_ok  = (count_q < CW'(LD_DEPTH));
  assign seq_io.ld_ready  = (count_q != '0);
  assign seq_io.busy_mask = busy;
  assign seq_io.wb_en     = wb_en_q;
  assign seq_io.wb_reg    = wb_reg_q;
  assign seq_io.wb_value  = wb_value_q;
endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - directed vector bench for writeback_sequencer
module tb_writeback_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  writeback_sequencer_if bus ();

  writeback_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .seq_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  ard;
    logic [31:0] ad;
    logic        li;
    logic [3:0]  lrd;
    logic        lv;
    logic [31:0] ld;
    logic        e_ar;
    logic        e_iok;
    logic        e_lr;
    logic [15:0] e_busy;
    logic        e_en;
    logic [3:0]  e_reg;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [3:0] ard, logic [31:0] ad,
                              logic li, logic [3:0] lrd, logic lv, logic [31:0] ld,
                              logic e_ar, logic e_iok, logic e_lr, logic [15:0] e_busy,
                              logic e_en, logic [3:0] e_reg, logic [31:0] e_val);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.li = li; v.lrd = lrd; v.lv = lv; v.ld = ld;
    v.e_ar = e_ar; v.e_iok = e_iok; v.e_lr = e_lr; v.e_busy = e_busy;
    v.e_en = e_en; v.e_reg = e_reg; v.e_val = e_val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic li, input logic [3:0] lrd, input logic lv, input logic [31:0] ld);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.ld_issue  = li; bus.ld_rd  = lrd;
    bus.ld_valid  = lv; bus.ld_data = ld;
  endtask

  initial begin
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);

    //           av ard  ad            li lrd  lv ld            ar iok lr busy      en reg val
    vecs.push_back(mk(1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 1, 4'd5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd3, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd7, 0, 32'h0,  1, 1, 1, 16'h0008, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd9, 0, 32'h0,  1, 0, 1, 16'h0088, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h11, 0, 0, 1, 16'h0088, 1, 4'd3, 32'h11));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h22, 0, 1, 1, 16'h0080, 1, 4'd7, 32'h22));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd2, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(1, 4'd4, 32'h44,       0, 4'd0, 1, 32'hAA, 0, 1, 1, 16'h0004, 1, 4'd2, 32'hAA));
    vecs.push_back(mk(1, 4'd4, 32'h44,       0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 1, 4'd4, 32'h44));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd6, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(1, 4'd6, 32'h66,       0, 4'd0, 0, 32'h0,  0, 1, 1, 16'h0040, 0, 4'd0, 32'h0));
    vecs.push_back(mk(1, 4'd6, 32'h66,       0, 4'd0, 1, 32'h60, 0, 1, 1, 16'h0040, 1, 4'd6, 32'h60));
    vecs.push_back(mk(1, 4'd6, 32'h66,       0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 1, 4'd6, 32'h66));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd0, 0, 32'h0,  1, 1, 1, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h5,  0, 0, 1, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h6,  0, 1, 1, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd8, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd8, 0, 32'h0,  1, 1, 1, 16'h0100, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h81, 0, 0, 1, 16'h0100, 1, 4'd8, 32'h81));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'h82, 0, 1, 1, 16'h0100, 1, 4'd8, 32'h82));
    vecs.push_back(mk(1, 4'd8, 32'h88,       0, 4'd0, 0, 32'h0,  1, 1, 0, 16'h0000, 1, 4'd8, 32'h88));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd1, 0, 32'h0,  1, 1, 0, 16'h0000, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        1, 4'd10,1, 32'h10, 0, 1, 1, 16'h0002, 1, 4'd1, 32'h10));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 0, 32'h0,  1, 1, 1, 16'h0400, 0, 4'd0, 32'h0));
    vecs.push_back(mk(0, 4'd0, 32'h0,        0, 4'd0, 1, 32'hA0, 0, 1, 1, 16'h0400, 1, 4'd10, 32'hA0));

    // Power-on reset state.
    @(negedge clk);
    chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
    chk("rst_wb_value", bus.wb_value, 32'd0);
    chk("rst_busy", 32'(bus.busy_mask), 32'd0);
    chk("rst_issue_ok", 32'(bus.issue_ok), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].li, vecs[i].lrd, vecs[i].lv, vecs[i].ld);
      @(negedge clk);
      chk($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d_issue_ok", i), 32'(bus.issue_ok), 32'(vecs[i].e_iok));
      chk($sformatf("v%0d_ld_ready", i), 32'(bus.ld_ready), 32'(vecs[i].e_lr));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy_mask), 32'(vecs[i].e_busy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wb_en", i), 32'(bus.wb_en), 32'(vecs[i].e_en));
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d_wb_reg", i), 32'(bus.wb_reg), 32'(vecs[i].e_reg));
        chk($sformatf("v%0d_wb_value", i), bus.wb_value, vecs[i].e_val);
      end
    end

    // Mid-cycle reset with two loads pending and a write pulse in flight.
    drive(1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 4'd13, 32'h1313, 1'b1, 4'd12, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);
    chk("pre_rst_wb_en", 32'(bus.wb_en), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy_mask), 32'h1800);
    chk("pre_rst_issue_ok", 32'(bus.issue_ok), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wb_en", 32'(bus.wb_en), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy_mask), 32'd0);
    chk("mid_rst_issue_ok", 32'(bus.issue_ok), 32'd1);
    chk("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stray load return after reset must not be accepted or written.
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b1, 32'hBAD);
    @(negedge clk);
    chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_wb_en", 32'(bus.wb_en), 32'd0);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
